// File: rtl/keypad_scan_matrix.sv
// Matrix keypad scanner: row strobing, frame debounce, single-key qualification and a valid/ready key event.
// Optional auto-repeat is compiled in when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_matrix #(
   parameter int ROWS                = 4,
   parameter int COLS                = 4,
   parameter int SETTLE_CYCLES       = 2,
   parameter int DEBOUNCE_FRAMES     = 8,
   parameter int REPEAT_DELAY_FRAMES = 64,
   parameter int REPEAT_RATE_FRAMES  = 16,
   parameter int CODE_W              = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ROWS-1:0]   row,
   input  logic [COLS-1:0]   col,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_down,
   output logic              multi_key,
   output logic              overflow
);

   localparam int NKEYS = ROWS * COLS;
   localparam int ROW_W = $clog2(ROWS);
   localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [ROW_W-1:0] R_LAST  = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
   localparam logic [CNT_W-1:0] DB_ONE  = CNT_W'(1);

   if (ROWS < 2 || COLS < 1 || SETTLE_CYCLES < 1 || DEBOUNCE_FRAMES < 1 ||
       REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_cfg_check
      $error("keypad_scan_matrix: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } state_t;

   logic [ROW_W-1:0]  r;
   logic [SC_W-1:0]   sc;
   logic [NKEYS-1:0]  frame_p0;
   logic              vld_p1;

   logic [1:0]        cnt;
   logic [CODE_W-1:0] idx;
   logic              single;
   logic              held;

   state_t            state;
   logic [CODE_W-1:0] cand;
   logic [CNT_W-1:0]  dcnt;
   logic [CNT_W-1:0]  rcnt;

   logic              emit;
   logic [CODE_W-1:0] emit_code;

   // Stage p0: strobe one row at a time and collect the pressed bits into the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r        <= '0;
         sc       <= '0;
         row      <= {{(ROWS-1){1'b1}}, 1'b0};
         frame_p0 <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         if (sc == SC_LAST) begin
            sc  <= '0;
            row <= {row[ROWS-2:0], row[ROWS-1]};
            for (int i = 0; i < ROWS; i++) begin
               if (r == ROW_W'(i)) frame_p0[i*COLS +: COLS] <= ~col;
            end
            if (r == R_LAST) begin
               r      <= '0;
               vld_p1 <= 1'b1;
            end else begin
               r <= r + ROW_W'(1);
            end
         end else begin
            sc <= sc + SC_W'(1);
         end
      end
   end

   // Stage p1: frame summary -- saturating key count and lowest pressed index
   always_comb begin
      cnt = 2'd0;
      idx = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (frame_p0[i]) begin
            if (cnt == 2'd0) idx = CODE_W'(i);
            if (cnt != 2'd2) cnt = cnt + 2'd1;
         end
      end
   end

   assign single = (cnt == 2'd1);
   assign held   = frame_p0[cand];

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES + 1);
   localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY_FRAMES);
   localparam logic [REP_W-1:0] REP_END = REP_W'(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES);

   logic [REP_W-1:0] rep;
   logic [REP_W-1:0] rep_next;
   logic             rep_hit;

   // rep parks at REP_DLY after the first repeat so the rate period can be counted from there
   assign rep_next = rep + REP_W'(1);
   assign rep_hit  = (rep_next == REP_DLY) || (rep_next == REP_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep <= '0;
      end else if (vld_p1) begin
         if (state != PRESSED) begin
            rep <= '0;
         end else if (held) begin
            rep <= (rep_next == REP_END) ? REP_DLY : rep_next;
         end
      end
   end
`endif

   always_comb begin
      emit      = 1'b0;
      emit_code = cand;
      if (vld_p1) begin
         case (state)
            IDLE: begin
               if (single && DEBOUNCE_FRAMES == 1) begin
                  emit      = 1'b1;
                  emit_code = idx;
               end
            end
            DEBOUNCE: begin
               if (single && idx == cand && dcnt == DB_LAST) emit = 1'b1;
            end
            PRESSED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (held && rep_hit) emit = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= '0;
         dcnt      <= '0;
         rcnt      <= '0;
         key_down  <= 1'b0;
         multi_key <= 1'b0;
      end else if (vld_p1) begin
         multi_key <= cnt[1];
         case (state)
            IDLE: begin
               if (single) begin
                  cand <= idx;
                  dcnt <= DB_ONE;
                  if (DEBOUNCE_FRAMES == 1) begin
                     state    <= PRESSED;
                     key_down <= 1'b1;
                     rcnt     <= '0;
                  end else begin
                     state <= DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (single && idx == cand) begin
                  if (dcnt == DB_LAST) begin
                     state    <= PRESSED;
                     key_down <= 1'b1;
                     rcnt     <= '0;
                  end else begin
                     dcnt <= dcnt + DB_ONE;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            PRESSED: begin
               // Other keys are ignored while the qualified key stays down
               if (held) begin
                  rcnt <= '0;
               end else if (rcnt == DB_LAST) begin
                  state    <= IDLE;
                  key_down <= 1'b0;
               end else begin
                  rcnt <= rcnt + DB_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Event register: an emit while an unaccepted event is pending is dropped and flagged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overflow  <= 1'b0;
      end else if (emit) begin
         if (!key_valid || key_ready) begin
            key_code  <= emit_code;
            key_valid <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (key_valid && key_ready) begin
         key_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_matrix.sv
// Bench for keypad_scan_matrix: a keypad model drives col from row; accepted events are scored against a queue.
module tb_keypad_scan_matrix;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready;
   logic        key_down;
   logic        multi_key;
   logic        overflow;

   logic [15:0] keys;
   int          vectors = 0;
   int          miscompares = 0;
   int          ev_cnt = 0;
   int          exp_events;
   logic [3:0]  exp_q[$];

   keypad_scan_matrix #(
      .ROWS(4), .COLS(4), .SETTLE_CYCLES(2), .DEBOUNCE_FRAMES(3),
      .REPEAT_DELAY_FRAMES(4), .REPEAT_RATE_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .key_down(key_down), .multi_key(multi_key), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its column low while its row is strobed
   always_comb begin
      col = 4'b1111;
      for (int rr = 0; rr < 4; rr++) begin
         if (!row[rr]) begin
            for (int cc = 0; cc < 4; cc++) begin
               if (keys[rr*4+cc]) col[cc] = 1'b0;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Return just after the edge that starts row 0 of a new frame
   task automatic align();
      logic [3:0] prev;
      bit         found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         prev = row;
         @(posedge clk);
         #1;
         if (row == 4'b1110 && prev != 4'b1110) found = 1'b1;
      end
      check_eq("align", int'(found), 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && key_valid && key_ready) begin
         ev_cnt++;
         if (exp_q.size() == 0) check_eq("sb_pending", exp_q.size(), 1);
         else check_eq("sb_code", int'(key_code), int'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      keys      = '0;
      key_ready = 1'b1;
      tick(3);
      check_eq("rst_row", int'(row), 4'b1110);
      check_eq("rst_code", int'(key_code), 0);
      check_eq("rst_valid", int'(key_valid), 0);
      check_eq("rst_down", int'(key_down), 0);
      check_eq("rst_multi", int'(multi_key), 0);
      check_eq("rst_ovf", int'(overflow), 0);
      rst_n = 1'b1;

      // Reset in the middle of a debounce, while row 2 is strobed
      align();
      keys = 16'(1) << 9;
      tick(21);
      check_eq("t1_row_mid", int'(row), 4'b1011);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t1_row_rst", int'(row), 4'b1110);
      check_eq("t1_valid_rst", int'(key_valid), 0);
      check_eq("t1_down_rst", int'(key_down), 0);
      keys = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(48);
      check_eq("t1_no_event", int'(key_valid), 0);

      // Single press of key 9 with the consumer stalled
      align();
      key_ready = 1'b0;
      keys      = 16'(1) << 9;
      exp_q.push_back(4'd9);
      tick(24);
      check_eq("t2_valid_early", int'(key_valid), 0);
      tick(1);
      check_eq("t2_valid", int'(key_valid), 1);
      check_eq("t2_code", int'(key_code), 9);
      check_eq("t2_down", int'(key_down), 1);
      check_eq("t2_multi", int'(multi_key), 0);
      tick(23);
      keys = '0;
      tick(24);
      check_eq("t2_down_hold", int'(key_down), 1);
      tick(1);
      check_eq("t2_down_fall", int'(key_down), 0);
      check_eq("t2_valid_held", int'(key_valid), 1);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      check_eq("t2_valid_clr", int'(key_valid), 0);

      // Bouncy press never reaches three identical frames
      align();
      key_ready = 1'b1;
      keys = 16'(1) << 9;
      tick(16);
      keys = '0;
      tick(8);
      keys = 16'(1) << 9;
      tick(16);
      keys = '0;
      tick(32);
      check_eq("t3_valid", int'(key_valid), 0);
      check_eq("t3_down", int'(key_down), 0);

      // Two keys together from idle
      align();
      keys = 16'b0000_0000_0010_0001;
      tick(9);
      check_eq("t4_multi_rise", int'(multi_key), 1);
      tick(39);
      check_eq("t4_multi_hold", int'(multi_key), 1);
      check_eq("t4_valid", int'(key_valid), 0);
      check_eq("t4_down", int'(key_down), 0);
      keys = '0;
      tick(9);
      check_eq("t4_multi_fall", int'(multi_key), 0);
      tick(24);

      // Second event while the first is pending is dropped
      align();
      key_ready = 1'b0;
      keys = 16'(1) << 3;
      exp_q.push_back(4'd3);
      tick(32);
      check_eq("t5_code_first", int'(key_code), 3);
      check_eq("t5_ovf_before", int'(overflow), 0);
      keys = '0;
      tick(32);
      keys = 16'(1) << 12;
      tick(32);
      keys = '0;
      tick(40);
      check_eq("t5_code_kept", int'(key_code), 3);
      check_eq("t5_ovf", int'(overflow), 1);
      check_eq("t5_valid", int'(key_valid), 1);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      check_eq("t5_valid_clr", int'(key_valid), 0);
      check_eq("t5_ovf_sticky", int'(overflow), 1);
      rst_n = 1'b0;
      #1;
      check_eq("t5_ovf_rst", int'(overflow), 0);
      tick(1);
      rst_n = 1'b1;

      // Long hold of key 7
      align();
      key_ready = 1'b1;
      ev_cnt    = 0;
      keys      = 16'(1) << 7;
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_events = 4;
`else
      exp_events = 1;
`endif
      for (int i = 0; i < exp_events; i++) exp_q.push_back(4'd7);
      tick(96);
      keys = '0;
      tick(40);
      check_eq("t6_events", ev_cnt, exp_events);
      check_eq("t6_down", int'(key_down), 0);

      check_eq("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
